// File: rtl/oam_dma_controller_if.sv
// oam_dma_controller_if: CPU-side request, DMA source-bus and PPU OAM write signals of the sprite DMA engine
interface oam_dma_controller_if;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_data_out;
  logic cpu_rw_n;
  logic [7:0] bus_data_in;
  logic cpu_halt;
  logic dma_active;
  logic [15:0] bus_addr;
  logic bus_rden;
  logic oam_wren;
  logic [7:0] oam_addr;
  logic [7:0] oam_data;
  modport master (
    output cpu_addr, cpu_data_out, cpu_rw_n, bus_data_in,
    input cpu_halt, dma_active, bus_addr, bus_rden, oam_wren, oam_addr, oam_data
  );
  modport slave (
    input cpu_addr, cpu_data_out, cpu_rw_n, bus_data_in,
    output cpu_halt, dma_active, bus_addr, bus_rden, oam_wren, oam_addr, oam_data
  );
endinterface

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: $4014 sprite DMA, copies one CPU page into PPU OAM with 2A03 halt/align timing
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int XFER_LEN = 256
) (
  input logic CLK,
  input logic RESET_n,
  input logic ENABLE,
  oam_dma_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
  state_t state, nxt;
  logic [7:0] page, idx, idx_nxt;
  logic parity;
  logic trigger;
  assign trigger = state == IDLE && !bus.cpu_rw_n && bus.cpu_addr == DMA_REG_ADDR;
  always_comb begin
    nxt = state;
    idx_nxt = idx;
    case (state)
      IDLE: nxt = trigger ? HALT : IDLE;
      HALT: nxt = parity ? READ : ALIGN;
      ALIGN: nxt = READ;
      READ: nxt = WRITE;
      WRITE: begin
        nxt = idx == LAST ? IDLE : READ;
        idx_nxt = idx == LAST ? 8'h0 : idx + 8'h1;
      end
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state; oam_data doubles as the read-data latch
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      state <= IDLE;
      page <= 8'h0;
      idx <= 8'h0;
      parity <= 1'b0;
      bus.cpu_halt <= 1'b0;
      bus.dma_active <= 1'b0;
      bus.bus_rden <= 1'b0;
      bus.bus_addr <= 16'h0;
      bus.oam_wren <= 1'b0;
      bus.oam_addr <= 8'h0;
      bus.oam_data <= 8'h0;
    end else if (ENABLE) begin
      state <= nxt;
      idx <= idx_nxt;
      parity <= ~parity;
      if (trigger) page <= bus.cpu_data_out;
      bus.cpu_halt <= nxt != IDLE;
      bus.dma_active <= nxt inside {ALIGN, READ, WRITE};
      bus.bus_rden <= nxt == READ;
      bus.bus_addr <= nxt == READ ? {page, idx_nxt} : 16'h0;
      bus.oam_wren <= nxt == WRITE;
      bus.oam_addr <= nxt == WRITE ? idx : 8'h0;
      bus.oam_data <= nxt == WRITE ? bus.bus_data_in : 8'h0;
    end
endmodule
